alu_sequencer: RTL

Multi-cycle 4-bit execution sequencer that sits directly upstream of the 4-bit ALU. It holds a 4×4-bit register file and a Z/C/S flag register, and accepts 9-bit instructions over a valid/ready handshake. For each instruction it drives registered operands, carry-in and opcode to the ALU, then writes the ALU result and flags back. It also provides a direct register-load port and a combinational register read port for setup and observation.

---
 rtl/alu_sequencer_if.sv | 38 +++
 rtl/alu_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Handshake, register-load, ALU and observation bundle of the 4-bit ALU sequencer.
// The master side is the upstream controller plus ALU; the slave side is the sequencer.
interface alu_sequencer_if;
  logic [8:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       ld_valid;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic       ld_ready;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [2:0] alu_op;
  logic [3:0] alu_r;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_sign;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [2:0] flags;
  logic       busy;
  logic       done;

  modport master (
    output instr, instr_valid, ld_valid, ld_addr, ld_data,
           alu_r, alu_zero, alu_carry, alu_sign, rd_addr,
    input  instr_ready, ld_ready, alu_a, alu_b, alu_cin, alu_op,
           rd_data, flags, busy, done
  );

  modport slave (
    input  instr, instr_valid, ld_valid, ld_addr, ld_data,
           alu_r, alu_zero, alu_carry, alu_sign, rd_addr,
    output instr_ready, ld_ready, alu_a, alu_b, alu_cin, alu_op,
           rd_data, flags, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Two-state sequencer feeding a combinational 4-bit ALU: latches operands on accept,
// writes result and {Z,C,S} flags back one cycle later.
module alu_sequencer (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t     state_r;
  logic [3:0] regs_r [4];
  logic [2:0] flags_r;
  logic [3:0] alu_a_r;
  logic [3:0] alu_b_r;
  logic       alu_cin_r;
  logic [2:0] alu_op_r;
  logic [1:0] rd_r;
  logic       no_write_r;
  logic       done_r;

  logic [2:0] op_s;
  logic [1:0] rd_s;
  logic [1:0] rs_s;
  logic [1:0] mode_s;

  // Carry-in selection; mode 2'b11 is a compare and always forces carry-in high.
  function automatic logic cin_sel(input logic [1:0] mode, input logic c_flag);
    logic cin;
    case (mode)
      2'b00:   cin = 1'b0;
      2'b01:   cin = 1'b1;
      2'b10:   cin = c_flag;
      2'b11:   cin = 1'b1;
      default: cin = 1'b0;
    endcase
    return cin;
  endfunction

  assign op_s   = bus.instr[8:6];
  assign rd_s   = bus.instr[5:4];
  assign rs_s   = bus.instr[3:2];
  assign mode_s = bus.instr[1:0];

  // Sequencer state, register file, flags and registered ALU drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 4'h0;
      end
      flags_r    <= 3'b000;
      alu_a_r    <= 4'h0;
      alu_b_r    <= 4'h0;
      alu_cin_r  <= 1'b0;
      alu_op_r   <= 3'b000;
      rd_r       <= 2'b00;
      no_write_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          // A pending load always wins the IDLE slot over an instruction.
          if (bus.ld_valid) begin
            regs_r[bus.ld_addr] <= bus.ld_data;
          end else if (bus.instr_valid) begin
            alu_a_r    <= regs_r[rd_s];
            alu_b_r    <= regs_r[rs_s];
            alu_op_r   <= op_s;
            alu_cin_r  <= cin_sel(mode_s, flags_r[1]);
            rd_r       <= rd_s;
            no_write_r <= (mode_s == 2'b11);
            state_r    <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (!no_write_r) begin
            regs_r[rd_r] <= bus.alu_r;
          end
          flags_r <= {bus.alu_zero, bus.alu_carry, bus.alu_sign};
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ld_ready    = (state_r == IDLE);
  assign bus.instr_ready = (state_r == IDLE) & ~bus.ld_valid;
  assign bus.busy        = (state_r == EXEC);
  assign bus.done        = done_r;
  assign bus.flags       = flags_r;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.alu_cin     = alu_cin_r;
  assign bus.alu_op      = alu_op_r;
  assign bus.rd_data     = regs_r[bus.rd_addr];

endmodule
